scic_io_port: RTL

SCIC_IO_PORT -- requirements
Module: scic_io_port

---
 rtl/scic_pkg.sv | 11 +
 rtl/scic_debounce.sv | 57 +++++
 rtl/scic_io_port.sv | 92 +++++++++
 3 files changed

// File: rtl/scic_pkg.sv
// Shared definitions for the SCIC switch/LED I/O port: register map constants.
package scic_pkg;

    typedef enum logic [1:0] {
        SW_STATE  = 2'd0,
        SW_CHANGE = 2'd1,
        LED       = 2'd2,
        IRQ_EN    = 2'd3
    } scic_addr_e;

endpackage

// File: rtl/scic_debounce.sv
// One switch channel: 2-flop synchroniser followed by a stable-count debouncer.
// chg pulses in the cycle before deb flips so the owner can latch a flag on the same edge.
module scic_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic deb,
    output logic chg
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             chg_s;

    // Acceptance happens on the edge where the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        chg_s = 1'b0;
        if ((sync2_r != deb_r) && (cnt_r == CNT_LAST)) begin
            chg_s = 1'b1;
        end else begin
            chg_s = 1'b0;
        end
    end

    // Synchroniser, stability counter and debounced state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            if (sync2_r == deb_r) begin
                cnt_r <= '0;
            end else if (chg_s) begin
                deb_r <= sync2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign deb = deb_r;
    assign chg = chg_s;

endmodule

// File: rtl/scic_io_port.sv
// Register-mapped switch input / LED output port with debounced change flags and a level irq.
module scic_io_port
    import scic_pkg::*;
#(
    parameter int NUM_SW          = 4,
    parameter int NUM_LED         = 4,
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  switches,
    output logic [NUM_LED-1:0] LEDs,
    input  logic [1:0]         addr,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic               irq
);

    logic [NUM_SW-1:0]  sw_state_s;
    logic [NUM_SW-1:0]  sw_set_s;
    logic [NUM_SW-1:0]  sw_clr_s;
    logic [NUM_SW-1:0]  sw_change_r;
    logic [NUM_SW-1:0]  irq_en_r;
    logic [NUM_LED-1:0] led_r;
    logic [DATA_W-1:0]  rd_mux_s;
    logic [DATA_W-1:0]  rd_data_r;
    logic               unused_wr_s;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        scic_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .pin   (switches[i]),
            .deb   (sw_state_s[i]),
            .chg   (sw_set_s[i])
        );
    end

    // Write-one-to-clear mask for the change flags.
    always_comb begin
        sw_clr_s = '0;
        if (wr_en && (addr == SW_CHANGE)) begin
            sw_clr_s = wr_data[NUM_SW-1:0];
        end else begin
            sw_clr_s = '0;
        end
    end

    // Read mux over current (pre-write) register contents, upper bits zero.
    always_comb begin
        rd_mux_s = '0;
        case (addr)
            SW_STATE:  rd_mux_s[NUM_SW-1:0]  = sw_state_s;
            SW_CHANGE: rd_mux_s[NUM_SW-1:0]  = sw_change_r;
            LED:       rd_mux_s[NUM_LED-1:0] = led_r;
            IRQ_EN:    rd_mux_s[NUM_SW-1:0]  = irq_en_r;
            default:   rd_mux_s              = '0;
        endcase
    end

    // Register file and read-data capture; a new transition beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_change_r <= '0;
            irq_en_r    <= '0;
            led_r       <= '0;
            rd_data_r   <= '0;
        end else begin
            sw_change_r <= (sw_change_r & ~sw_clr_s) | sw_set_s;
            if (wr_en && (addr == LED)) begin
                led_r <= wr_data[NUM_LED-1:0];
            end
            if (wr_en && (addr == IRQ_EN)) begin
                irq_en_r <= wr_data[NUM_SW-1:0];
            end
            if (rd_en) begin
                rd_data_r <= rd_mux_s;
            end
        end
    end

    assign unused_wr_s = ^wr_data;
    assign LEDs        = led_r;
    assign rd_data     = rd_data_r;
    assign irq         = |(sw_change_r & irq_en_r);

endmodule
